// File: rtl/simem_pkg.sv
// Shared types and line constants for the serial instruction-memory link.
// Used by the memory-side responder and the CPU-side serializers.
package simem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX_ADDR,
      LOOKUP,
      TX_START,
      TX_DATA
   } simem_state_t;

   localparam logic SIMEM_START_BIT  = 1'b1;
   localparam logic SIMEM_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/simem_array.sv
// Word storage for the serial instruction-memory responder.
// Synchronous write port plus a synchronous read port.
// A read and a write to the same address in one cycle return the old word.
module simem_array
   import simem_pkg::*;
#(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write and registered read share the edge; the read sees the pre-write contents.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/serial_imem_responder.sv
// Memory-side end of the serial instruction-fetch link.
// Receives a framed MSB-first address on addr_in and returns the stored word
// as a framed MSB-first stream on instr_out (start bit 1, idle level 0).
// Optional build macro SIMEM_PARITY_EN appends an even-parity bit after the data.
module serial_imem_responder
   import simem_pkg::*;
#(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              addr_in,
   output logic              instr_out,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic [CNT_W-1:0]  served_cnt
);

`ifdef SIMEM_PARITY_EN
   localparam int unsigned PAR_W = 1;
`else
   localparam int unsigned PAR_W = 0;
`endif

   // Bits sent after the start bit: data plus the optional parity bit.
   localparam int unsigned TX_W    = DATA_W + PAR_W;
   localparam int unsigned MAX_LEN = (ADDR_W > TX_W) ? ADDR_W : TX_W;
   localparam int unsigned BC_W    = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

   simem_state_t      state;
   logic [ADDR_W-1:0] rx_sr;
   logic [TX_W-1:0]   tx_sr;
   logic [BC_W-1:0]   bit_cnt;
   logic [DATA_W-1:0] rd_data;
   logic              rd_en_c;
   logic [TX_W-1:0]   tx_load_c;

   assign rd_en_c = (state == LOOKUP);

`ifdef SIMEM_PARITY_EN
   assign tx_load_c = {rd_data, ^rd_data};
`else
   assign tx_load_c = rd_data;
`endif

   simem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en_c),
      .rd_addr (rx_sr),
      .rd_data (rd_data)
   );

   // Frame FSM: address receive, array lookup, start bit, payload shift-out.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         instr_out  <= SIMEM_IDLE_LEVEL;
         busy       <= 1'b0;
         served_cnt <= '0;
         rx_sr      <= '0;
         tx_sr      <= '0;
         bit_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               instr_out <= SIMEM_IDLE_LEVEL;
               if (addr_in == SIMEM_START_BIT) begin
                  state   <= RX_ADDR;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
               end
            end

            RX_ADDR: begin
               rx_sr <= {rx_sr[ADDR_W-2:0], addr_in};
               if (bit_cnt == BC_W'(ADDR_W - 1)) begin
                  state   <= LOOKUP;
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + BC_W'(1);
               end
            end

            // The array captures the word at this edge; start bit goes out next cycle.
            LOOKUP: begin
               state     <= TX_START;
               instr_out <= SIMEM_START_BIT;
            end

            // First payload bit comes straight from the array output.
            TX_START: begin
               state     <= TX_DATA;
               instr_out <= tx_load_c[TX_W-1];
               tx_sr     <= {tx_load_c[TX_W-2:0], 1'b0};
               bit_cnt   <= '0;
            end

            TX_DATA: begin
               if (bit_cnt == BC_W'(TX_W - 1)) begin
                  state      <= IDLE;
                  instr_out  <= SIMEM_IDLE_LEVEL;
                  busy       <= 1'b0;
                  served_cnt <= served_cnt + CNT_W'(1);
                  bit_cnt    <= '0;
               end else begin
                  instr_out <= tx_sr[TX_W-1];
                  tx_sr     <= {tx_sr[TX_W-2:0], 1'b0};
                  bit_cnt   <= bit_cnt + BC_W'(1);
               end
            end

            default: begin
               state     <= IDLE;
               instr_out <= SIMEM_IDLE_LEVEL;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_imem_responder.sv
// Directed bench for serial_imem_responder (default 6-bit address, 16-bit data).
module tb_serial_imem_responder;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 8;

   logic          clock;
   logic          reset;
   logic          addr_in;
   logic          instr_out;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic [CW-1:0] served_cnt;

   int            n_checks;
   int            n_fail;
   logic [CW-1:0] exp_cnt;

   serial_imem_responder #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .CNT_W  (CW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .addr_in    (addr_in),
      .instr_out  (instr_out),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .served_cnt (served_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      cyc();
      wr_en   = 1'b0;
   endtask

   // Issue one request and check every cycle of the response frame.
   task automatic run_frame(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                            input logic lk_wr, input logic [AW-1:0] lk_addr,
                            input logic [DW-1:0] lk_data, input logic hold, input int abort_bit);
      addr_in = 1'b1;
      cyc();
      check({tag, ".start_busy"}, 32'(busy), 32'd1);
      for (int i = AW - 1; i >= 0; i--) begin
         addr_in = a[i];
         cyc();
         check($sformatf("%s.rx%0d_out", tag, i), 32'(instr_out), 32'd0);
      end
      check({tag, ".lookup_out"}, 32'(instr_out), 32'd0);
      check({tag, ".lookup_busy"}, 32'(busy), 32'd1);
      addr_in = hold;
      if (lk_wr) begin
         wr_en   = 1'b1;
         wr_addr = lk_addr;
         wr_data = lk_data;
      end
      cyc();
      wr_en = 1'b0;
      check({tag, ".start_bit"}, 32'(instr_out), 32'd1);
      for (int k = 0; k < int'(DW); k++) begin
         cyc();
         check($sformatf("%s.bit%0d", tag, k), 32'(instr_out), 32'(exp[DW-1-k]));
         check($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'd1);
         if (k == abort_bit) begin
            reset = 1'b1;
            cyc();
            reset   = 1'b0;
            addr_in = 1'b0;
            exp_cnt = '0;
            check({tag, ".abort_out"}, 32'(instr_out), 32'd0);
            check({tag, ".abort_busy"}, 32'(busy), 32'd0);
            check({tag, ".abort_cnt"}, 32'(served_cnt), 32'(exp_cnt));
            cyc();
            check({tag, ".abort_out2"}, 32'(instr_out), 32'd0);
            return;
         end
      end
`ifdef SIMEM_PARITY_EN
      cyc();
      check({tag, ".parity"}, 32'(instr_out), 32'(^exp));
      check({tag, ".parity_busy"}, 32'(busy), 32'd1);
`endif
      cyc();
      exp_cnt = exp_cnt + CW'(1);
      check({tag, ".end_out"}, 32'(instr_out), 32'd0);
      check({tag, ".end_busy"}, 32'(busy), 32'd0);
      check({tag, ".end_cnt"}, 32'(served_cnt), 32'(exp_cnt));
   endtask

   // Guard against a stuck simulation.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Directed sequence.
   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_cnt  = '0;
      reset    = 1'b1;
      addr_in  = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      cyc();
      cyc();
      check("rst_out", 32'(instr_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cnt", 32'(served_cnt), 32'd0);
      reset = 1'b0;
      cyc();
      check("idle_busy", 32'(busy), 32'd0);

      write_word(6'h2D, 16'hA5C3);
      write_word(6'h3F, 16'h8001);
      write_word(6'h12, 16'h1234);
      write_word(6'h00, 16'h0F0F);
      write_word(6'h07, 16'h0007);
      cyc();

      run_frame("f1", 6'h2D, 16'hA5C3, 1'b0, '0, '0, 1'b0, -1);
      run_frame("b2b", 6'h3F, 16'h8001, 1'b0, '0, '0, 1'b0, -1);

      run_frame("rbw_old", 6'h12, 16'h1234, 1'b1, 6'h12, 16'hFFFF, 1'b0, -1);
      run_frame("rbw_new", 6'h12, 16'hFFFF, 1'b0, '0, '0, 1'b0, -1);

      run_frame("oth_wr", 6'h2D, 16'hA5C3, 1'b1, 6'h3F, 16'h0000, 1'b0, -1);
      run_frame("oth_rd", 6'h3F, 16'h0000, 1'b0, '0, '0, 1'b0, -1);

      run_frame("abort", 6'h2D, 16'hA5C3, 1'b0, '0, '0, 1'b0, 4);
      run_frame("post_abort", 6'h2D, 16'hA5C3, 1'b0, '0, '0, 1'b0, -1);

      run_frame("hold", 6'h00, 16'h0F0F, 1'b0, '0, '0, 1'b1, -1);
      addr_in = 1'b0;
      cyc();
      check("hold_idle1", 32'(busy), 32'd0);
      cyc();
      check("hold_idle2", 32'(busy), 32'd0);
      check("hold_idle_out", 32'(instr_out), 32'd0);
      check("hold_idle_cnt", 32'(served_cnt), 32'(exp_cnt));

      run_frame("w7", 6'h07, 16'h0007, 1'b0, '0, '0, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
